// File: rtl/sramlike_ram_responder.sv
// Responder end of the req/addr_ok/data_ok SRAM-like bus: in-order pipelined
// read/write service from an internal word RAM with programmable response latency.
module sramlike_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  input  logic        stall_i
);

  localparam int              PTR_W     = $clog2(OUTSTANDING);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [PTR_W:0]  FULL_C    = (PTR_W + 1)'(OUTSTANDING);
  localparam logic [3:0]      CD_LOAD_C = 4'(LATENCY - 1);

  logic [31:0]       mem_r   [DEPTH];
  logic [31:0]       rdata_r [OUTSTANDING];
  logic [3:0]        cd_r    [OUTSTANDING];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;
  logic              accept_s;
  logic              pop_s;
  logic [ADDR_W-1:0] idx_s;
  logic              unused_s;

  // data_size is informational; byte offset and aliased upper address bits are dropped
  assign unused_s = ^{data_size, data_addr[1:0], data_addr[31:ADDR_W+2]};
  assign idx_s    = data_addr[ADDR_W+1:2];

  // A full queue blocks acceptance even in a cycle where the head pops
  assign accept_s     = ~rst & data_req & ~stall_i & (count_r < FULL_C);
  assign pop_s        = ~rst & (count_r != '0) & (cd_r[head_r] == 4'd0);
  assign data_addr_ok = accept_s;
  assign data_data_ok = pop_s;
  assign data_rdata   = pop_s ? rdata_r[head_r] : 32'h0;

  // RAM write port: byte-masked update at acceptance; contents survive reset
  always_ff @(posedge clk) begin
    if (accept_s && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wstrb[b]) begin
          mem_r[idx_s][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue payload: read data captured at acceptance, every countdown ticks toward zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        rdata_r[i] <= 32'h0;
        cd_r[i]    <= 4'd0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (accept_s && (tail_r == PTR_W'(i))) begin
          rdata_r[i] <= data_wr ? 32'h0 : mem_r[idx_s];
          cd_r[i]    <= CD_LOAD_C;
        end else if (cd_r[i] != 4'd0) begin
          cd_r[i] <= cd_r[i] - 4'd1;
        end
      end
    end
  end

  // Queue pointers (wrap modulo OUTSTANDING) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (accept_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
